// File: rtl/vx_csr_arb_pkg.sv
// CSR arbiter shared helpers.
// Index and counter width functions keyed on parameters.
package vx_csr_arb_pkg;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int ptr_w(input int d);
    return $clog2(d);
  endfunction

  function automatic int cnt_w(input int d);
    return $clog2(d) + 1;
  endfunction

endpackage

// File: rtl/vx_csr_arb_rr.sv
// Combinational round-robin picker.
// Priority starts one past the last grant and wraps.
module vx_csr_arb_rr #(
  parameter int NUM_REQS = 2,
  parameter int IDXW     = 1
) (
  input  logic [NUM_REQS-1:0] requests,
  input  logic [IDXW-1:0]     last_grant,
  output logic [IDXW-1:0]     grant_index,
  output logic                grant_valid
);

  // Scan lowest priority first so the highest-priority hit wins last.
  always_comb begin
    grant_index = '0;
    grant_valid = 1'b0;
    for (int i = NUM_REQS; i >= 1; i--) begin
      int idx;
      idx = (int'(last_grant) + i) % NUM_REQS;
      if (requests[idx]) begin
        grant_index = IDXW'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vx_csr_arb.sv
// Arbitrates issue slots onto one CSR unit.
// Tracks grant order in a tag FIFO to route commits back.
module vx_csr_arb
  import vx_csr_arb_pkg::*;
#(
  parameter int NUM_REQS  = 2,
  parameter int DATAW     = 64,
  parameter int RSP_DATAW = 64,
  parameter int TAG_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       req_valid,
  input  logic [NUM_REQS*DATAW-1:0] req_data,
  output logic [NUM_REQS-1:0]       req_ready,
  output logic                      out_valid,
  output logic [DATAW-1:0]          out_data,
  input  logic                      out_ready,
  input  logic                      rsp_in_valid,
  input  logic [RSP_DATAW-1:0]      rsp_in_data,
  output logic                      rsp_in_ready,
  output logic [NUM_REQS-1:0]       rsp_out_valid,
  output logic [RSP_DATAW-1:0]      rsp_out_data,
  input  logic [NUM_REQS-1:0]       rsp_out_ready
);

  localparam int IDXW = idx_w(NUM_REQS);
  localparam int PTRW = ptr_w(TAG_DEPTH);
  localparam int CNTW = cnt_w(TAG_DEPTH);

  logic [IDXW-1:0] last_q, last_d;
  logic [IDXW-1:0] lock_idx_q, lock_idx_d;
  logic            lock_q, lock_d;
  logic [PTRW-1:0] wr_q, wr_d;
  logic [PTRW-1:0] rd_q, rd_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [IDXW-1:0] tags_q [TAG_DEPTH];
  logic [IDXW-1:0] tags_d [TAG_DEPTH];

  logic [IDXW-1:0] arb_idx;
  logic            arb_vld;
  logic [IDXW-1:0] grant;
  logic [IDXW-1:0] head;
  logic            tag_full;
  logic            tag_empty;
  logic            push;
  logic            pop;

  vx_csr_arb_rr #(
    .NUM_REQS (NUM_REQS),
    .IDXW     (IDXW)
  ) u_rr (
    .requests    (req_valid),
    .last_grant  (last_q),
    .grant_index (arb_idx),
    .grant_valid (arb_vld)
  );

  // Request side: locked grant, forwarding and ready fan-out.
  always_comb begin
    tag_full  = (cnt_q == CNTW'(TAG_DEPTH));
    tag_empty = (cnt_q == '0);
    head      = tags_q[rd_q];
    grant     = lock_q ? lock_idx_q : arb_idx;
    out_valid = !reset && arb_vld && !tag_full;
    out_data  = req_data[grant*DATAW +: DATAW];
    push      = out_valid && out_ready;
    req_ready = '0;
    req_ready[grant] = push;
  end

  // Response side: route commit to the oldest outstanding requester.
  always_comb begin
    rsp_out_data  = rsp_in_data;
    rsp_in_ready  = !reset && !tag_empty && rsp_out_ready[head];
    pop           = rsp_in_valid && rsp_in_ready;
    rsp_out_valid = '0;
    rsp_out_valid[head] = !reset && rsp_in_valid && !tag_empty;
  end

  // Next-state for lock, priority pointer and tag FIFO.
  always_comb begin
    last_d     = last_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    tags_d     = tags_q;
    if (out_valid && !out_ready) begin
      lock_d     = 1'b1;
      lock_idx_d = grant;
    end
    if (push) begin
      lock_d       = 1'b0;
      last_d       = grant;
      tags_d[wr_q] = grant;
      wr_d         = wr_q + PTRW'(1);
    end
    if (pop) begin
      rd_d = rd_q + PTRW'(1);
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNTW'(1);
      2'b01:   cnt_d = cnt_q - CNTW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; tag storage needs no reset.
  always_ff @(posedge clk) begin
    tags_q <= tags_d;
    if (reset) begin
      last_q     <= IDXW'(NUM_REQS - 1);
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
    end else begin
      last_q     <= last_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
    end
  end

  a_rsp_without_tag: assert property (
    @(posedge clk) disable iff (reset) !(rsp_in_valid && tag_empty)
  );

endmodule

// File: tb/tb_vx_csr_arb.sv
// Bench for vx_csr_arb: queue-based model plus directed scenarios.
// Default parameters: two requesters, four tags.
module tb_vx_csr_arb;

  localparam int N     = 2;
  localparam int DW    = 64;
  localparam int RW    = 64;
  localparam int DEPTH = 4;
  localparam logic [63:0] A0 = 64'h0000_0000_0000_00A0;
  localparam logic [63:0] B1 = 64'h0000_0000_0000_00B1;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_ready;
  logic            rsp_in_valid;
  logic [RW-1:0]   rsp_in_data;
  logic            rsp_in_ready;
  logic [N-1:0]    rsp_out_valid;
  logic [RW-1:0]   rsp_out_data;
  logic [N-1:0]    rsp_out_ready;

  int checks = 0;
  int errors = 0;

  vx_csr_arb #(
    .NUM_REQS  (N),
    .DATAW     (DW),
    .RSP_DATAW (RW),
    .TAG_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .rsp_in_valid  (rsp_in_valid),
    .rsp_in_data   (rsp_in_data),
    .rsp_in_ready  (rsp_in_ready),
    .rsp_out_valid (rsp_out_valid),
    .rsp_out_data  (rsp_out_data),
    .rsp_out_ready (rsp_out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Behavioural model: last grant, lock, and queue of owners.
  int m_lg = N - 1;
  bit m_lock = 1'b0;
  int m_lidx = 0;
  int q[$];

  function automatic int m_grant();
    if (m_lock) return m_lidx;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_lg + k) % N;
      if (req_valid[idx]) return idx;
    end
    return 0;
  endfunction

  int         mg;
  bit         mev;
  bit         mpop;
  bit         mir;
  logic [N-1:0] mrr;
  logic [N-1:0] mrv;

  initial begin
    forever begin
      @(negedge clk);
      mg  = m_grant();
      mev = !reset && (|req_valid) && (q.size() < DEPTH);
      mrr = '0;
      if (mev && out_ready) mrr[mg] = 1'b1;
      mir = !reset && (q.size() > 0) && rsp_out_ready[q[0]];
      mrv = '0;
      if (!reset && (q.size() > 0) && rsp_in_valid) mrv[q[0]] = 1'b1;
      chk("m_out_valid", 64'(out_valid), 64'(mev));
      if (mev) chk("m_out_data", out_data, req_data[mg*DW +: DW]);
      chk("m_req_ready", 64'(req_ready), 64'(mrr));
      chk("m_rsp_in_ready", 64'(rsp_in_ready), 64'(mir));
      chk("m_rsp_out_valid", 64'(rsp_out_valid), 64'(mrv));
      chk("m_rsp_out_data", rsp_out_data, rsp_in_data);
      if (reset) begin
        q.delete();
        m_lg   = N - 1;
        m_lock = 1'b0;
      end else begin
        mpop = (q.size() > 0) && rsp_in_valid && rsp_out_ready[q[0]];
        if (mpop) void'(q.pop_front());
        if (mev && out_ready) begin
          q.push_back(mg);
          m_lg   = mg;
          m_lock = 1'b0;
        end else if (mev) begin
          m_lock = 1'b1;
          m_lidx = mg;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    rsp_in_data = {$urandom, $urandom};
  endtask

  initial begin
    logic [1:0] drain_a [4];
    drain_a[0] = 2'b10;
    drain_a[1] = 2'b01;
    drain_a[2] = 2'b10;
    drain_a[3] = 2'b10;

    reset         = 1'b1;
    req_valid     = 2'b11;
    req_data      = {B1, A0};
    out_ready     = 1'b1;
    rsp_in_valid  = 1'b0;
    rsp_in_data   = '0;
    rsp_out_ready = 2'b11;
    tick();
    tick();
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_in_ready", 64'(rsp_in_ready), 64'd0);
    reset = 1'b0;

    // Alternating grants, then FIFO fills.
    for (int k = 0; k < 4; k++) begin
      #2;
      chk("rr_out_data", out_data, (k % 2 == 1) ? B1 : A0);
      chk("rr_out_valid", 64'(out_valid), 64'd1);
      tick();
    end
    rsp_in_valid = 1'b1;
    #2;
    chk("full_out_valid", 64'(out_valid), 64'd0);
    chk("full_req_ready", 64'(req_ready), 64'd0);
    chk("pop_head0", 64'(rsp_out_valid), 64'h1);
    chk("pop_ready", 64'(rsp_in_ready), 64'd1);
    tick();
    rsp_in_valid = 1'b0;
    req_valid    = 2'b10;
    #2;
    chk("after_pop_valid", 64'(out_valid), 64'd1);
    chk("after_pop_data", out_data, B1);
    tick();

    // Drain in order: owners 1,0,1,1.
    req_valid    = 2'b00;
    rsp_in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #2;
      chk("drain_route", 64'(rsp_out_valid), 64'(drain_a[k]));
      tick();
    end
    rsp_in_valid = 1'b0;

    // Grant lock while out_ready is low.
    req_valid = 2'b10;
    out_ready = 1'b0;
    #2;
    chk("lock_c1", out_data, B1);
    tick();
    req_valid = 2'b11;
    #2;
    chk("lock_c2", out_data, B1);
    tick();
    #2;
    chk("lock_c3", out_data, B1);
    tick();
    out_ready = 1'b1;
    #2;
    chk("lock_hs_data", out_data, B1);
    chk("lock_hs_ready", 64'(req_ready), 64'h2);
    tick();
    #2;
    chk("lock_next_data", out_data, A0);
    chk("lock_next_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b00;
    out_ready = 1'b0;

    // Head stalled, then push and pop together at count 2.
    rsp_in_valid  = 1'b1;
    rsp_out_ready = 2'b01;
    #2;
    chk("stall_ready", 64'(rsp_in_ready), 64'd0);
    chk("stall_route", 64'(rsp_out_valid), 64'h2);
    tick();
    #2;
    chk("stall_hold", 64'(rsp_out_valid), 64'h2);
    rsp_out_ready = 2'b11;
    req_valid     = 2'b01;
    out_ready     = 1'b1;
    #2;
    chk("pp_rsp_ready", 64'(rsp_in_ready), 64'd1);
    chk("pp_out_valid", 64'(out_valid), 64'd1);
    tick();
    rsp_in_valid = 1'b0;
    #2;
    chk("pp_fill1", 64'(out_valid), 64'd1);
    tick();
    #2;
    chk("pp_fill2", 64'(out_valid), 64'd1);
    tick();
    #2;
    chk("pp_full", 64'(out_valid), 64'd0);

    // Reset with three outstanding tags.
    req_valid    = 2'b00;
    rsp_in_valid = 1'b1;
    #2;
    chk("pre_rst_route", 64'(rsp_out_valid), 64'h1);
    tick();
    reset     = 1'b1;
    req_valid = 2'b11;
    #2;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_rsp_ready", 64'(rsp_in_ready), 64'd0);
    chk("mid_rst_rsp_valid", 64'(rsp_out_valid), 64'd0);
    tick();
    reset        = 1'b0;
    rsp_in_valid = 1'b0;
    #2;
    chk("post_rst_empty", 64'(rsp_in_ready), 64'd0);
    chk("post_rst_data", out_data, A0);
    chk("post_rst_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b00;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vx_csr_arb.md
VX_CSR_ARB -- requirements
Module: VX_csr_arb

Interface
REQ-001 SHALL have parameter NUM_REQS, default 2: number of issue-slot requesters sharing one CSR unit (legal range 1-8).
REQ-002 SHALL have parameter DATAW, default 64: width of the request payload forwarded to the CSR unit.
REQ-003 SHALL have parameter RSP_DATAW, default 64: width of the commit payload returned by the CSR unit.
REQ-004 SHALL have parameter TAG_DEPTH, default 4: maximum number of outstanding requests (power of two, ≥2).
REQ-005 SHALL have port clk, input, 1: the single clock.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port req_valid, input, NUM_REQS: per-requester request valid.
REQ-008 SHALL have port req_data, input, NUM_REQS×DATAW: per-requester payload.
REQ-009 SHALL have port req_ready, output, NUM_REQS: per-requester accept.
REQ-010 SHALL have port out_valid, output, 1: request valid to the CSR unit.
REQ-011 SHALL have port out_data, output, DATAW: granted payload.
REQ-012 SHALL have port out_ready, input, 1: CSR unit accept.
REQ-013 SHALL have port rsp_in_valid, input, 1: commit valid from the CSR unit.
REQ-014 SHALL have port rsp_in_data, input, RSP_DATAW: commit payload.
REQ-015 SHALL have port rsp_in_ready, output, 1: commit accept.
REQ-016 SHALL have port rsp_out_valid, output, NUM_REQS: commit valid routed to the originating requester.
REQ-017 SHALL have port rsp_out_data, output, RSP_DATAW: commit payload broadcast to all requesters.
REQ-018 SHALL have port rsp_out_ready, input, NUM_REQS: per-requester commit accept.

Function
REQ-019 SHALL arbitrate round-robin: priority starts at (last_grant+1) mod NUM_REQS and wraps; last_grant updates only on an out_valid&&out_ready handshake.
REQ-020 SHALL forward the winner combinationally (0-cycle latency): out_valid = |req_valid && !tag_full; out_data = req_data[grant].
REQ-021 SHALL lock the grant while out_valid && !out_ready: the grant index is held until the handshake completes, even if a higher-priority requester asserts valid.
REQ-022 SHALL assert req_ready[i] only when i is the current grant && out_ready && !tag_full.
REQ-023 SHALL push the grant index into an in-order tag FIFO on every out handshake.
REQ-024 SHALL route each response to the requester at the FIFO head: rsp_out_valid[head] = rsp_in_valid && !tag_empty; all other bits are 0.
REQ-025 SHALL set rsp_in_ready = rsp_out_ready[head] && !tag_empty, and pop the FIFO on an rsp_in handshake.
REQ-026 SHALL block new grants when the outstanding count == TAG_DEPTH (out_valid=0), even if a pop occurs in the same cycle; this keeps the rsp→req path free of combinational loops.
REQ-027 SHALL allow a push and a pop in the same cycle when not full; the count is then unchanged.
REQ-028 SHALL hold rsp_in_ready=0 while the FIFO is empty; an rsp_in_valid with an empty FIFO is a protocol error, flagged by a simulation assertion.
REQ-029 SHALL keep the outstanding count width at $clog2(TAG_DEPTH)+1 and the pointers at $clog2(TAG_DEPTH), with pointer wrap modulo TAG_DEPTH.
REQ-030 SHALL, with NUM_REQS=1, degenerate to a pass-through with tag tracking; the grant is constant 0.

Reset
REQ-031 SHALL on reset clear the count, both pointers and the lock, and set last_grant = NUM_REQS-1 so requester 0 has first priority.
REQ-032 SHALL drive out_valid=0, req_ready=0, rsp_in_ready=0 and rsp_out_valid=0 while reset is high; reset mid-transaction discards all outstanding tags.

Structure
REQ-033 SHALL place NUM_REQS-dependent index width helpers in VX_gpu_pkg; no new typedefs are needed.
REQ-034 SHALL instantiate the existing round-robin arbiter sub-module (VX_rr_arbiter) for grant selection; the tag FIFO, lock and count SHALL be local logic.

Verification
REQ-035 SHALL cover: req_valid=2'b11 continuously with out_ready=1 → grants alternate 0,1,0,1 starting with 0 after reset.
REQ-036 SHALL cover: req1 valid, out_ready=0 for 3 cycles, req0 asserts in cycle 2 → out_data stays req1 until handshake; req0 is granted next.
REQ-037 SHALL cover: TAG_DEPTH=4, 4 handshakes with no responses → out_valid=0 on the 5th; one rsp pop → out_valid=1 in the following cycle.
REQ-038 SHALL cover: responses returned in order for a grant sequence 1,0,1 → rsp_out_valid one-hot 2'b10, 2'b01, 2'b10.
REQ-039 SHALL cover: rsp_out_ready[head]=0 → rsp_in_ready=0 and the FIFO is unchanged; simultaneous push+pop at count=2 → count stays 2.
REQ-040 SHALL cover: reset asserted with 3 outstanding → count=0 next cycle; a subsequent request is granted to requester 0.
